display_scan_ctrl: RTL and testbench

//  Time-multiplexed scan controller for the 6-digit 7-segment display.

---
 rtl/display_scan_ctrl.sv | 161 ++++++++++++++++
 tb/tb_display_scan_ctrl.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/display_scan_ctrl.sv
// Time-multiplexed scan controller for a 6-digit 7-segment display.
// Inserts blanking gaps, swaps displayed data only at frame boundaries, and can suppress leading zeros.
module display_scan_ctrl #(
   parameter int CLK_DIV   = 50000,
   parameter int BLANK_CYC = 16
) (
   input  logic        sys_clk,
   input  logic        sys_rst,
   input  logic        en,
   input  logic        lz_en,
   input  logic [23:0] data_in,
   input  logic        data_vld,
   output logic [2:0]  bit_disp,
   output logic [3:0]  data_disp,
   output logic        frame_done
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      BLANK = 2'd1,
      SHOW  = 2'd2
   } state_t;

   localparam int              CNT_MAX    = (CLK_DIV > BLANK_CYC) ? CLK_DIV : BLANK_CYC;
   localparam int              CNT_W      = $clog2(CNT_MAX + 1);
   localparam logic [CNT_W-1:0] SHOW_LAST  = CNT_W'(CLK_DIV - 1);
   localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'((BLANK_CYC > 0) ? BLANK_CYC - 1 : 0);
   localparam state_t          GAP_STATE  = (BLANK_CYC > 0) ? BLANK : SHOW;
   localparam logic [2:0]      BLANK_CODE = 3'b111;
   localparam logic [2:0]      LAST_IDX   = 3'd5;

   state_t           state, state_nxt;
   logic [CNT_W-1:0] cnt, cnt_nxt;
   logic [2:0]       idx, idx_nxt;
   logic             frame_end;

   logic [23:0]      active, shadow, active_nxt;
   logic             pending;
   logic             load_active;

   logic [3:0]       nib [8];
   logic [7:0]       upper_zero;
   logic [2:0]       bit_nxt;
   logic [3:0]       data_nxt;

   // State register
   // NOTE: clocked blocks use non-blocking assignments only, so every register
   // samples pre-edge values and simulation matches the synthesized flops.
   always_ff @(posedge sys_clk) begin
      if (sys_rst) begin
         state <= IDLE;
         cnt   <= '0;
         idx   <= '0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
         idx   <= idx_nxt;
      end
   end

   // Next-state logic
   // NOTE: every combinational output gets a default first, so no path leaves
   // a signal unassigned and no latch is inferred.
   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      idx_nxt   = idx;
      frame_end = 1'b0;
      unique case (state)
         IDLE: begin
            if (en) begin
               state_nxt = GAP_STATE;
               cnt_nxt   = '0;
               idx_nxt   = '0;
            end
         end
         BLANK: begin
            if (!en) begin
               state_nxt = IDLE;
               cnt_nxt   = '0;
               idx_nxt   = '0;
            end else if (cnt == BLANK_LAST) begin
               state_nxt = SHOW;
               cnt_nxt   = '0;
            end else begin
               cnt_nxt = cnt + 1'b1;
            end
         end
         SHOW: begin
            if (!en) begin
               state_nxt = IDLE;
               cnt_nxt   = '0;
               idx_nxt   = '0;
            end else if (cnt == SHOW_LAST) begin
               state_nxt = GAP_STATE;
               cnt_nxt   = '0;
               frame_end = (idx == LAST_IDX);
               idx_nxt   = (idx == LAST_IDX) ? 3'd0 : idx + 3'd1;
            end else begin
               cnt_nxt = cnt + 1'b1;
            end
         end
         default: begin
            state_nxt = IDLE;
            cnt_nxt   = '0;
            idx_nxt   = '0;
         end
      endcase
   end

   // Displayed value only changes while idle or on the 5->0 wrap, so a frame never mixes values.
   assign load_active = (state == IDLE) || frame_end;

   always_comb begin
      active_nxt = active;
      if (load_active && (pending || data_vld))
         active_nxt = data_vld ? data_in : shadow;
   end

   // Output logic, evaluated on next-cycle values so the registered outputs line up with the state.
   always_comb begin
      for (int k = 0; k < 8; k++)
         nib[k] = (k < 6) ? active_nxt[4*k +: 4] : 4'd0;

      upper_zero = '0;
      upper_zero[5] = (nib[5] == 4'd0);
      for (int k = 4; k >= 0; k--)
         upper_zero[k] = upper_zero[k+1] && (nib[k] == 4'd0);

      bit_nxt  = BLANK_CODE;
      data_nxt = 4'd0;
      if (state_nxt == SHOW) begin
         data_nxt = nib[idx_nxt];
         bit_nxt  = (lz_en && (idx_nxt != 3'd0) && upper_zero[idx_nxt]) ? BLANK_CODE : idx_nxt;
      end
   end

   // Data path and registered outputs
   always_ff @(posedge sys_clk) begin
      if (sys_rst) begin
         active     <= '0;
         shadow     <= '0;
         pending    <= 1'b0;
         bit_disp   <= BLANK_CODE;
         data_disp  <= 4'd0;
         frame_done <= 1'b0;
      end else begin
         active <= active_nxt;
         if (data_vld)
            shadow <= data_in;
         if (load_active)
            pending <= 1'b0;
         else if (data_vld)
            pending <= 1'b1;
         bit_disp   <= bit_nxt;
         data_disp  <= data_nxt;
         frame_done <= frame_end;
      end
   end

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Bench for display_scan_ctrl: two instances (4/2 and 1/0 timing) driven by the same
// scripted + random stimulus and compared every cycle against a frame-position model.
module tb_display_scan_ctrl;

   logic        clk = 1'b0;
   logic        rst, en, lz, vld;
   logic [23:0] din;

   logic [2:0]  bd0, bd1;
   logic [3:0]  dd0, dd1;
   logic        fd0, fd1;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;

   always #5 clk = ~clk;

   display_scan_ctrl #(.CLK_DIV(4), .BLANK_CYC(2)) u_dut_a (
      .sys_clk(clk), .sys_rst(rst), .en(en), .lz_en(lz), .data_in(din), .data_vld(vld),
      .bit_disp(bd0), .data_disp(dd0), .frame_done(fd0)
   );

   display_scan_ctrl #(.CLK_DIV(1), .BLANK_CYC(0)) u_dut_b (
      .sys_clk(clk), .sys_rst(rst), .en(en), .lz_en(lz), .data_in(din), .data_vld(vld),
      .bit_disp(bd1), .data_disp(dd1), .frame_done(fd1)
   );

   // Reference model: position within the frame plus the value latched for the frame.
   int          cdiv [2] = '{4, 1};
   int          bcyc [2] = '{2, 0};
   bit          run  [2];
   int          pos  [2];
   logic [23:0] act  [2];
   logic [23:0] shad [2];
   logic [2:0]  e_bd [2];
   logic [3:0]  e_dd [2];
   logic        e_fd [2];

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL %s @cyc %0d: got %0h expected %0h", tag, cyc, obs, exp);
      end
   endtask

   task automatic model_step(input int i);
      int p, slot, d;
      logic [23:0] upper;
      p = bcyc[i] + cdiv[i];
      e_fd[i] = 1'b0;
      if (rst) begin
         run[i]  = 1'b0;
         pos[i]  = 0;
         act[i]  = '0;
         shad[i] = '0;
      end else if (!run[i]) begin
         if (vld) shad[i] = din;
         act[i] = shad[i];
         if (en) begin
            run[i] = 1'b1;
            pos[i] = 0;
         end
      end else if (!en) begin
         run[i] = 1'b0;
         if (vld) shad[i] = din;
      end else begin
         if (vld) shad[i] = din;
         if (pos[i] == 6*p - 1) begin
            e_fd[i] = 1'b1;
            act[i]  = shad[i];
            pos[i]  = 0;
         end else begin
            pos[i]++;
         end
      end
      e_bd[i] = 3'd7;
      e_dd[i] = 4'd0;
      if (run[i]) begin
         slot = pos[i] % p;
         d    = pos[i] / p;
         if (slot >= bcyc[i]) begin
            upper   = act[i] >> (4*d);
            e_dd[i] = upper[3:0];
            e_bd[i] = (lz && d > 0 && upper == 24'd0) ? 3'd7 : 3'(d);
         end
      end
   endtask

   task automatic apply_inputs(input int c, inout int en_hold);
      int sh;
      vld = 1'b0;
      if (c < 3) begin
         rst = 1'b1; en = 1'b1; lz = 1'b0; din = '0;
      end else if (c < 41) begin
         rst = 1'b0; en = 1'b1;
      end else if (c == 41) begin
         en = 1'b0;
      end else if (c == 42) begin
         vld = 1'b1; din = 24'h123456;
      end else if (c < 121) begin
         en = 1'b1;
         if (c == 86) begin vld = 1'b1; din = 24'hABCDEF; end
      end else if (c == 121) begin
         en = 1'b0; lz = 1'b1; vld = 1'b1; din = 24'h000120;
      end else if (c < 200) begin
         en = 1'b1;
         if (c == 158) begin vld = 1'b1; din = 24'h000000; end
      end else begin
         rst = ($urandom_range(0, 399) == 0);
         if (en_hold > 0) begin
            en_hold--;
            en = 1'b0;
         end else if ($urandom_range(0, 119) == 0) begin
            en_hold = $urandom_range(0, 5);
            en = 1'b0;
         end else begin
            en = 1'b1;
         end
         if ($urandom_range(0, 59) == 0) lz = ~lz;
         if ($urandom_range(0, 14) == 0) begin
            sh  = $urandom_range(0, 6);
            vld = 1'b1;
            din = 24'($urandom) & (24'hFFFFFF >> (4*sh));
         end
      end
   endtask

   initial begin
      int en_hold;
      en_hold = 0;
      rst = 1'b1; en = 1'b1; lz = 1'b0; vld = 1'b0; din = '0;
      model_step(0);
      model_step(1);
      for (int c = 1; c <= 3000; c++) begin
         @(negedge clk);
         cyc = c;
         check("a.bit_disp",   32'(bd0), 32'(e_bd[0]));
         check("a.data_disp",  32'(dd0), 32'(e_dd[0]));
         check("a.frame_done", 32'(fd0), 32'(e_fd[0]));
         check("b.bit_disp",   32'(bd1), 32'(e_bd[1]));
         check("b.data_disp",  32'(dd1), 32'(e_dd[1]));
         check("b.frame_done", 32'(fd1), 32'(e_fd[1]));
         apply_inputs(c, en_hold);
         model_step(0);
         model_step(1);
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
